am_envelope_demod: RTL and testbench
====================================

# am_envelope_demod

Envelope demodulator for the loop-back/receive path of the two-way voice link: it consumes the signed AM samples produced by the AM modulator stage (or the receive ADC chain carrying the same format) and recovers the baseband audio. Full-wave rectification feeds an integrate-and-dump decimator, and an optional DC-tracking high-pass strips the carrier-level offset. A squelch mutes the output when the carrier is absent. The output is a signed audio sample stream with a one-cycle valid strobe.

## Interface
- `INPUT_WIDTH`, 12: width of signed `wave_in`; also width of `audio_out`.
- `DECIM_LOG2`, 8: log2 of samples per output block (decimation factor 2^DECIM_LOG2), 1..12.
- `DC_SHIFT`, 10: DC tracker time constant, α = 2^-DC_SHIFT, 1..16.

- `clk_in` in 1: single clock.
- `RST_n` in 1: asynchronous active-low reset.
- `wave_in` in INPUT_WIDTH: signed two's-complement AM sample.
- `wave_valid` in 1: `wave_in` is accepted on the rising edge where this is high.
- `squelch_level` in INPUT_WIDTH-1: unsigned carrier threshold, quasi-static.
- `env_out` out INPUT_WIDTH-1: unsigned block-mean envelope.
- `audio_out` out INPUT_WIDTH: signed recovered audio.
- `carrier_ok` out 1: last block mean ≥ `squelch_level`.
- `out_valid` out 1: one-cycle strobe qualifying `env_out`, `audio_out` and `carrier_ok`.

## Operation
- **Rectify stage.** On a valid edge, register `rect = |wave_in|` and pipeline `wave_valid`. The most negative input -2^(INPUT_WIDTH-1) saturates to 2^(INPUT_WIDTH-1)-1, so `rect` is INPUT_WIDTH-1 bits unsigned.
- **Integrate stage.**
  - Accumulator is INPUT_WIDTH-1+DECIM_LOG2 bits unsigned and never overflows.
  - Counter is DECIM_LOG2 bits.
  - On each valid `rect`: if count < 2^DECIM_LOG2-1, `acc += rect` and `count++`.
  - Otherwise, dump: `mean = (acc + rect) >> DECIM_LOG2` (truncate), `acc <= 0`, `count` wraps to 0, and an internal `mean_valid` is raised for one cycle.
  - Invalid cycles leave `acc` and `count` unchanged.
- **Output stage FSM, states WARMUP and RUN. Reset state is WARMUP.**
  - WARMUP + `mean_valid`:
    - load `dc_acc <= mean << DC_SHIFT`;
    - go to RUN;
    - no `out_valid`.
  - RUN + `mean_valid`:
    - `dc = dc_acc >> DC_SHIFT`;
    - `audio = mean - dc`, signed INPUT_WIDTH; it always fits, so no saturation;
    - `dc_acc <= dc_acc + mean - dc`, unsigned INPUT_WIDTH-1+DC_SHIFT bits;
    - register outputs, assert `out_valid`.
  - Squelch: `carrier_ok = (mean >= squelch_level)`. When 0, `audio_out` is forced to 0. `env_out` is still reported and `dc_acc` still updates.
- No backpressure: a downstream consumer must take each strobe.
- Reset mid-block: acc, count, pipeline valid, state and all outputs clear immediately. The partial block is discarded.

## Timing
- Reset values: `env_out`=0, `audio_out`=0, `carrier_ok`=0, `out_valid`=0, `acc`=0, `count`=0, `dc_acc`=0, state WARMUP.
- The last sample of a block is accepted at edge E0.
- `mean` is formed at E1.
- Outputs update at E2, and `out_valid` is high for the cycle following E2. Latency is 2 edges after acceptance.
- Outputs hold their value between strobes.
- Back-to-back valid input at full rate gives one `out_valid` every 2^DECIM_LOG2 cycles.
- `wave_valid` gaps stretch the block; they never shorten it.
- With DC_BLOCK_EN, the first `out_valid` after reset corresponds to the second complete block.

## Configuration
- `AM_DEMOD_DC_BLOCK_EN` defined:
  - the WARMUP/RUN FSM and DC tracker are compiled in, as described above.
- Not defined:
  - no `dc_acc` and no FSM; the block behaves as permanently RUN;
  - `audio_out = {1'b0, mean}`, squelch still applied;
  - the first block after reset produces `out_valid`.

## Test plan
- **No macro, DECIM_LOG2=2, squelch 0.**
  - Stimulus: continuous `wave_in` alternating +100/-100.
  - Response: `out_valid` every 4 cycles, `env_out`=100, `audio_out`=100, `carrier_ok`=1. The first strobe comes 2 edges after the 4th accepted sample.
- **Saturation, DECIM_LOG2=2.**
  - Stimulus: constant -2048.
  - Response: `env_out`=2047.
- **Macro on, DECIM_LOG2=2, DC_SHIFT=4.**
  - Stimulus: constant ±1000.
  - Response: no strobe for block 1. Every later block gives `env_out`=1000, `audio_out`=0.
  - Stimulus: step the amplitude to 1200.
  - Response: first `audio_out`=200, then decaying toward 0.
- **Squelch.**
  - Stimulus: `squelch_level`=500, amplitude 200.
  - Response: `carrier_ok`=0, `audio_out`=0, `env_out`=200.
  - Stimulus: raise amplitude to 600.
  - Response: `carrier_ok`=1.
- **Gapped valid.**
  - Stimulus: `wave_valid` high every 3rd cycle, DECIM_LOG2=2.
  - Response: strobe every 12 cycles, same values as continuous input.
- **Reset mid-block.**
  - Stimulus: assert `RST_n`=0 after 2 of 4 samples, release, then feed 4 samples of 300.
  - Response: all outputs 0 during reset. With the macro off, the first strobe gives `env_out`=300. With the macro on, there is no strobe for that block (WARMUP).

Source files
------------

// File: rtl/am_envelope_demod.sv
// am_envelope_demod
// Envelope demodulator for the two-way voice link receive/loop-back path.
// The signed AM input is full-wave rectified, then averaged over blocks of
// 2^DECIM_LOG2 valid samples (integrate-and-dump). When the build macro
// AM_DEMOD_DC_BLOCK_EN is defined, a first-order DC tracker removes the
// carrier level from the block mean; otherwise the mean itself is the audio.
// A squelch forces the audio to zero when the block mean is below threshold.
//
// Ports
//   clk_in        in   1               single clock
//   RST_n         in   1               asynchronous active-low reset
//   wave_in       in   INPUT_WIDTH     signed AM sample
//   wave_valid    in   1               wave_in accepted on this rising edge
//   squelch_level in   INPUT_WIDTH-1   unsigned carrier threshold
//   env_out       out  INPUT_WIDTH-1   unsigned block-mean envelope
//   audio_out     out  INPUT_WIDTH     signed recovered audio
//   carrier_ok    out  1               last block mean >= squelch_level
//   out_valid     out  1               one-cycle strobe for the outputs
//
// Latency: last sample of a block accepted at E0, mean formed at E1,
// outputs registered at E2 (out_valid high for the cycle after E2).

module am_envelope_demod #(
  parameter int unsigned INPUT_WIDTH = 12,
  parameter int unsigned DECIM_LOG2  = 8,
  parameter int unsigned DC_SHIFT    = 10
) (
  input  logic                          clk_in,
  input  logic                          RST_n,
  input  logic signed [INPUT_WIDTH-1:0] wave_in,
  input  logic                          wave_valid,
  input  logic        [INPUT_WIDTH-2:0] squelch_level,
  output logic        [INPUT_WIDTH-2:0] env_out,
  output logic signed [INPUT_WIDTH-1:0] audio_out,
  output logic                          carrier_ok,
  output logic                          out_valid
);

  localparam int unsigned RW = INPUT_WIDTH - 1;     // rectified / mean width
  localparam int unsigned AW = RW + DECIM_LOG2;     // block accumulator width
  localparam int unsigned CW = DECIM_LOG2;          // block sample counter width
  localparam int unsigned DW = RW + DC_SHIFT;       // DC tracker state width

  // Elaboration-time parameter range guard
  if (INPUT_WIDTH < 2) begin : g_bad_width
    $error("am_envelope_demod: INPUT_WIDTH must be at least 2");
  end
  if (DECIM_LOG2 < 1 || DECIM_LOG2 > 12) begin : g_bad_decim
    $error("am_envelope_demod: DECIM_LOG2 must be in 1..12");
  end
  if (DC_SHIFT < 1 || DC_SHIFT > 16) begin : g_bad_shift
    $error("am_envelope_demod: DC_SHIFT must be in 1..16");
  end

  // ---------------------------------------------------------------------
  // Rectify stage
  // ---------------------------------------------------------------------
  logic              w_neg;
  logic              w_most_neg;
  logic [INPUT_WIDTH-1:0] w_negated;
  logic [RW-1:0]     w_rect;

  logic [RW-1:0]     r_rect;
  logic              r_rect_vld;

  // The most negative code has no positive twin; clamp it to full scale.
  always_comb begin
    w_neg      = wave_in[INPUT_WIDTH-1];
    w_most_neg = w_neg && (wave_in[RW-1:0] == '0);
    w_negated  = -wave_in;
    if (w_most_neg) begin
      w_rect = '1;
    end else if (w_neg) begin
      w_rect = w_negated[RW-1:0];
    end else begin
      w_rect = wave_in[RW-1:0];
    end
  end

  // Register |wave_in| and pipeline its valid
  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      r_rect     <= '0;
      r_rect_vld <= 1'b0;
    end else begin
      r_rect_vld <= wave_valid;
      if (wave_valid) begin
        r_rect <= w_rect;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Integrate-and-dump stage
  // ---------------------------------------------------------------------
  logic [AW-1:0] w_sum;
  logic          w_last;
  logic [RW-1:0] w_mean_next;

  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_mean;
  logic          r_mean_vld;

  // AW bits hold 2^DECIM_LOG2 full-scale samples, so the sum cannot wrap.
  always_comb begin
    w_sum       = r_acc + AW'(r_rect);
    w_last      = &r_cnt;
    w_mean_next = RW'(w_sum >> DECIM_LOG2);
  end

  // Accumulate valid samples; dump the mean on the last one of each block
  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mean     <= '0;
      r_mean_vld <= 1'b0;
    end else begin
      r_mean_vld <= 1'b0;
      if (r_rect_vld) begin
        if (w_last) begin
          r_acc      <= '0;
          r_cnt      <= '0;
          r_mean     <= w_mean_next;
          r_mean_vld <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic                          w_ok;
  logic signed [INPUT_WIDTH-1:0] w_audio_raw;

  logic        [RW-1:0]          r_env;
  logic signed [INPUT_WIDTH-1:0] r_audio;
  logic                          r_ok;
  logic                          r_out_vld;

  assign w_ok = (r_mean >= squelch_level);

`ifdef AM_DEMOD_DC_BLOCK_EN

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_dc_acc;
  logic [RW-1:0] w_dc;
  logic [DW-1:0] w_dc_acc_next;

  // Tracker output is the integer part of dc_acc; both operands are
  // non-negative and below 2^RW, so their difference fits INPUT_WIDTH.
  always_comb begin
    w_dc          = RW'(r_dc_acc >> DC_SHIFT);
    w_audio_raw   = {1'b0, r_mean} - {1'b0, w_dc};
    w_dc_acc_next = r_dc_acc + DW'(r_mean) - DW'(w_dc);
  end

  // WARMUP seeds the tracker from the first block mean; RUN reports blocks
  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= ST_WARMUP;
      r_dc_acc  <= '0;
      r_env     <= '0;
      r_audio   <= '0;
      r_ok      <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      if (r_mean_vld) begin
        case (r_state)
          ST_WARMUP: begin
            r_dc_acc <= DW'(r_mean) << DC_SHIFT;
            r_state  <= ST_RUN;
          end
          ST_RUN: begin
            r_dc_acc  <= w_dc_acc_next;
            r_env     <= r_mean;
            r_audio   <= w_ok ? w_audio_raw : '0;
            r_ok      <= w_ok;
            r_out_vld <= 1'b1;
          end
          default: begin
            r_state <= ST_WARMUP;
          end
        endcase
      end
    end
  end

`else

  // Without DC removal the zero-extended mean is the audio sample
  assign w_audio_raw = {1'b0, r_mean};

  // Report every block
  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      r_env     <= '0;
      r_audio   <= '0;
      r_ok      <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      if (r_mean_vld) begin
        r_env     <= r_mean;
        r_audio   <= w_ok ? w_audio_raw : '0;
        r_ok      <= w_ok;
        r_out_vld <= 1'b1;
      end
    end
  end

`endif

  assign env_out    = r_env;
  assign audio_out  = r_audio;
  assign carrier_ok = r_ok;
  assign out_valid  = r_out_vld;

endmodule

// File: tb/tb_am_envelope_demod.sv
// Testbench for am_envelope_demod (DECIM_LOG2=2, DC_SHIFT=4).
// Table rows describe a tone segment and its expected envelope/squelch;
// a reference model pushes expected strobes (values and arrival cycle) to a
// queue as samples are driven, and a negedge monitor pops and compares.
// Expected audio follows the build: with AM_DEMOD_DC_BLOCK_EN the model
// runs the DC tracker and skips the warm-up block after each reset.

module tb_am_envelope_demod;

  localparam int unsigned IW   = 12;
  localparam int unsigned DL   = 2;
  localparam int unsigned DS   = 4;
  localparam int          BLK  = 1 << DL;
  localparam int          NVEC = 7;

  logic                 clk_in;
  logic                 RST_n;
  logic signed [IW-1:0] wave_in;
  logic                 wave_valid;
  logic        [IW-2:0] squelch_level;
  logic        [IW-2:0] env_out;
  logic signed [IW-1:0] audio_out;
  logic                 carrier_ok;
  logic                 out_valid;

  am_envelope_demod #(
    .INPUT_WIDTH (IW),
    .DECIM_LOG2  (DL),
    .DC_SHIFT    (DS)
  ) dut (
    .clk_in        (clk_in),
    .RST_n         (RST_n),
    .wave_in       (wave_in),
    .wave_valid    (wave_valid),
    .squelch_level (squelch_level),
    .env_out       (env_out),
    .audio_out     (audio_out),
    .carrier_ok    (carrier_ok),
    .out_valid     (out_valid)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int amp;       // sample value (sign alternates when alt is set)
    bit alt;
    int squelch;
    int gap;       // wave_valid high one cycle in every gap cycles
    int blocks;
    bit do_reset;
    int exp_env;
    bit exp_ok;
  } vec_t;

  typedef struct {
    int env;
    int audio;
    bit ok;
    int cyc;
  } exp_t;

  vec_t tbl [NVEC];
  exp_t sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state
  int m_cnt    = 0;
  bit m_warm   = 1'b0;
  int m_dc_acc = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected result for one completed block
  task automatic model_block(input int env, input bit ok, input int due);
    exp_t e;
    int   dc;
    int   a;
    e.env = env;
    e.ok  = ok;
    e.cyc = due;
`ifdef AM_DEMOD_DC_BLOCK_EN
    if (!m_warm) begin
      m_dc_acc = env << DS;
      m_warm   = 1'b1;
      return;
    end
    dc       = m_dc_acc >> DS;
    a        = env - dc;
    m_dc_acc = m_dc_acc + env - dc;
`else
    dc = 0;
    a  = env;
`endif
    e.audio = ok ? a : 0;
    sb_q.push_back(e);
  endtask

  // One cycle of stimulus, driven just after the falling edge
  task automatic drive(input int s, input bit v, input int exp_env, input bit exp_ok);
    @(negedge clk_in);
    #1;
    wave_in    = IW'(s);
    wave_valid = v;
    if (v) begin
      m_cnt++;
      if (m_cnt == BLK) begin
        m_cnt = 0;
        model_block(exp_env, exp_ok, cyc + 3);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_env"},   int'(env_out), 0);
    check({tag, "_audio"}, int'(audio_out), 0);
    check({tag, "_ok"},    int'(carrier_ok), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk_in);
    #1;
    RST_n      = 1'b0;
    wave_valid = 1'b0;
    wave_in    = '0;
    m_cnt      = 0;
    m_warm     = 1'b0;
    m_dc_acc   = 0;
    #1;
    check_zero_outputs(tag);
    @(negedge clk_in);
    #1;
    RST_n = 1'b1;
  endtask

  // Strobe monitor: compare each out_valid against the scoreboard
  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got out_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("env_out",      int'(env_out), e.env);
        check("audio_out",    int'(audio_out), e.audio);
        check("carrier_ok",   int'(carrier_ok), int'(e.ok));
      end
    end
  end

  initial begin
    int k;
    int s;
    //          amp    alt   sq   gap blk rst  env   ok
    tbl[0] = '{  100,  1'b1,   0, 1,  3, 1'b0,  100, 1'b1};
    tbl[1] = '{-2048,  1'b0,   0, 1,  2, 1'b0, 2047, 1'b1};
    tbl[2] = '{ 1000,  1'b1,   0, 1,  3, 1'b1, 1000, 1'b1};
    tbl[3] = '{ 1200,  1'b1,   0, 1,  4, 1'b0, 1200, 1'b1};
    tbl[4] = '{  200,  1'b1, 500, 1,  2, 1'b0,  200, 1'b0};
    tbl[5] = '{  600,  1'b1, 500, 1,  2, 1'b0,  600, 1'b1};
    tbl[6] = '{  100,  1'b1,   0, 3,  2, 1'b0,  100, 1'b1};

    RST_n         = 1'b0;
    wave_in       = '0;
    wave_valid    = 1'b0;
    squelch_level = '0;
    repeat (2) @(negedge clk_in);
    #1;
    check_zero_outputs("reset_state");
    RST_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].do_reset) reset_pulse("row_reset");
      squelch_level = (IW-1)'(tbl[i].squelch);
      k = 0;
      for (int b = 0; b < tbl[i].blocks; b++) begin
        for (int j = 0; j < BLK; j++) begin
          s = (tbl[i].alt && (k % 2 == 1)) ? -tbl[i].amp : tbl[i].amp;
          drive(s, 1'b1, tbl[i].exp_env, tbl[i].exp_ok);
          for (int g = 1; g < tbl[i].gap; g++) drive(0, 1'b0, 0, 1'b0);
          k++;
        end
      end
      repeat (5) drive(0, 1'b0, 0, 1'b0);
    end

    // Reset in the middle of a block: the partial block must be discarded
    squelch_level = '0;
    drive(300, 1'b1, 300, 1'b1);
    drive(-300, 1'b1, 300, 1'b1);
    reset_pulse("mid_block_reset");
    for (int j = 0; j < 2 * BLK; j++) drive((j % 2 == 0) ? 300 : -300, 1'b1, 300, 1'b1);
    repeat (5) drive(0, 1'b0, 0, 1'b0);

    check("queue_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
